vend_credit_fsm: RTL
====================

Name: vend_credit_fsm

Overview:
Parametrised coin-credit controller for the vending datapath. It takes coin insertions by coin code and converts each to a value through an internal per-coin value table. It accumulates credit with overflow rejection, services vend requests against a supplied price, and returns change or refunds through a valid/ack handshake. It sits between the coin-slot front end and the product dispenser / change hopper.

Parameters:
WIDTH, 8, bit width of credit, price and change values
SEL_W, 2, width of coin select code (2^SEL_W coin types)
COIN0, 5, value of coin code 0
COIN1, 10, value of coin code 1
COIN2, 25, value of coin code 2
COIN3, 100, value of coin code 3 (codes above 3, when SEL_W>2, have value 0 and are rejected)
MAX_CREDIT, 200, credit ceiling; must be < 2^WIDTH

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
COIN_VALID  in  1  one-cycle strobe: coin present on COIN_SEL
COIN_SEL  in  SEL_W  coin type code
COIN_ACK  out  1  registered pulse: coin accepted, credit updated
COIN_REJ  out  1  registered pulse: coin rejected, must be returned to user
PRICE  in  WIDTH  price of selected product, sampled with VEND_REQ
VEND_REQ  in  1  one-cycle strobe: purchase request
VEND_OK  out  1  registered pulse: dispense product
VEND_DENY  out  1  registered pulse: insufficient credit
CANCEL  in  1  one-cycle strobe: refund all credit
CHANGE_VALID  out  1  change/refund amount valid, held until acked
CHANGE  out  WIDTH  change/refund amount, stable while CHANGE_VALID
CHANGE_ACK  in  1  hopper has taken CHANGE
CREDIT  out  WIDTH  current credit, registered
BUSY  out  1  high in REFUND state

Behaviour:
- Reset (async, RST_N=0): state IDLE; CREDIT=0, CHANGE=0; all pulse outputs, CHANGE_VALID and BUSY = 0. Reset mid-refund discards the pending change.
- States: IDLE (credit 0), HOLD (credit > 0), REFUND (change outstanding).
- Coin value: combinational lookup from COIN_SEL. Sum is computed at WIDTH+1 bits.
- Per-cycle priority in IDLE/HOLD: CANCEL > VEND_REQ > COIN_VALID. Any coin strobed in the same cycle as CANCEL or VEND_REQ is rejected.
- Coin accept: value != 0 and CREDIT+value <= MAX_CREDIT. On the next edge CREDIT += value, COIN_ACK=1 for 1 cycle, IDLE->HOLD. Otherwise COIN_REJ=1 for 1 cycle and CREDIT is unchanged. Latency is 1 clock.
- VEND_REQ with CREDIT >= PRICE:
  - next edge VEND_OK=1 for 1 cycle;
  - if CREDIT-PRICE > 0: CHANGE=CREDIT-PRICE, CHANGE_VALID=1, CREDIT=0, go to REFUND;
  - else CREDIT=0, go to IDLE.
  - PRICE=0 is a legal free vend.
- VEND_REQ with CREDIT < PRICE: VEND_DENY=1 for 1 cycle; state and credit unchanged.
- CANCEL in HOLD: CHANGE=CREDIT, CHANGE_VALID=1, CREDIT=0, go to REFUND. CANCEL in IDLE is ignored (no pulse).
- REFUND:
  - BUSY=1.
  - Every COIN_VALID gets COIN_REJ.
  - VEND_REQ gets VEND_DENY.
  - CANCEL is ignored.
  - CHANGE_VALID=1 and CHANGE are held until a cycle with CHANGE_ACK=1. On the next edge CHANGE_VALID=0, CHANGE=0, go to IDLE.
  - CHANGE_ACK outside REFUND is ignored.
- Pulse outputs are never asserted for more than one cycle per input strobe. At most one of COIN_ACK/COIN_REJ and at most one of VEND_OK/VEND_DENY fire per cycle.

Decomposition:
- Shared include vend_defs.vh holds:
  - state encodings (ST_IDLE=2'd0, ST_HOLD=2'd1, ST_REFUND=2'd2);
  - default coin codes/values (nickel=0/5, dime=1/10, quarter=2/25, dollar=3/100);
  - default MAX_CREDIT.
- One sub-module, coin_value_lut: parametrised combinational SEL_W -> WIDTH value table with COIN0..COIN3 parameters, instantiated once.
- The FSM, accumulator and handshake logic live in the top module.

Test Plan:
- Reset, then coins 2,2,0 on separate cycles -> COIN_ACK x3, CREDIT 25,50,55; state HOLD.
- CREDIT=55, VEND_REQ PRICE=50 -> VEND_OK pulse, CHANGE=5, CHANGE_VALID held 4 cycles until CHANGE_ACK, then IDLE, CREDIT=0.
- CREDIT=190, coin 1 (10) -> COIN_ACK, CREDIT=200. Then coin 0 (5) -> COIN_REJ, CREDIT stays 200.
- CREDIT=30, VEND_REQ PRICE=35 -> VEND_DENY, CREDIT=30. Same cycle COIN_VALID code 0 -> COIN_REJ.
- CREDIT=100, CANCEL with VEND_REQ same cycle -> no VEND_OK, CHANGE=100 refund. During REFUND coin 3 -> COIN_REJ, BUSY=1.
- Assert RST_N low mid-REFUND (CHANGE=45) -> immediate CHANGE_VALID=0, CREDIT=0. After release, state IDLE.

Source files
------------

// File: rtl/vend_credit_fsm_pkg.sv
// Shared definitions for the vending credit controller: state encodings,
// default coin codes/values and the default credit ceiling.
package vend_credit_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REFUND = 2'd2
    } state_t;

    localparam int COIN_NICKEL  = 0;
    localparam int COIN_DIME    = 1;
    localparam int COIN_QUARTER = 2;
    localparam int COIN_DOLLAR  = 3;

    localparam int VAL_NICKEL  = 5;
    localparam int VAL_DIME    = 10;
    localparam int VAL_QUARTER = 25;
    localparam int VAL_DOLLAR  = 100;

    localparam int DEF_MAX_CREDIT = 200;

endpackage

// File: rtl/vend_credit_fsm_coin_value_lut.sv
// Combinational coin-code to value table; codes beyond the four defined
// coin types map to zero, which the controller treats as a reject.
module coin_value_lut
    import vend_credit_fsm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2,
    parameter int COIN0 = VAL_NICKEL,
    parameter int COIN1 = VAL_DIME,
    parameter int COIN2 = VAL_QUARTER,
    parameter int COIN3 = VAL_DOLLAR
) (
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] value
);

    logic [31:0] code;

    // Widen before comparing so narrow SEL_W never aliases onto a defined code.
    assign code = 32'(sel);

    always_comb begin
        value = '0;
        case (code)
            32'(COIN_NICKEL):  value = WIDTH'(COIN0);
            32'(COIN_DIME):    value = WIDTH'(COIN1);
            32'(COIN_QUARTER): value = WIDTH'(COIN2);
            32'(COIN_DOLLAR):  value = WIDTH'(COIN3);
            default:           value = '0;
        endcase
    end

endmodule

// File: rtl/vend_credit_fsm.sv
// Coin-credit controller: accumulates coin value, services vend requests
// against a price and returns change/refunds through a valid/ack handshake.
module vend_credit_fsm
    import vend_credit_fsm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SEL_W      = 2,
    parameter int COIN0      = VAL_NICKEL,
    parameter int COIN1      = VAL_DIME,
    parameter int COIN2      = VAL_QUARTER,
    parameter int COIN3      = VAL_DOLLAR,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             COIN_VALID,
    input  logic [SEL_W-1:0] COIN_SEL,
    output logic             COIN_ACK,
    output logic             COIN_REJ,
    input  logic [WIDTH-1:0] PRICE,
    input  logic             VEND_REQ,
    output logic             VEND_OK,
    output logic             VEND_DENY,
    input  logic             CANCEL,
    output logic             CHANGE_VALID,
    output logic [WIDTH-1:0] CHANGE,
    input  logic             CHANGE_ACK,
    output logic [WIDTH-1:0] CREDIT,
    output logic             BUSY
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] credit_q, credit_d;
    logic [WIDTH-1:0] change_q, change_d;
    logic             change_valid_q, change_valid_d;
    logic             coin_ack_q, coin_ack_d;
    logic             coin_rej_q, coin_rej_d;
    logic             vend_ok_q, vend_ok_d;
    logic             vend_deny_q, vend_deny_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] coin_val;
    logic [WIDTH:0]   coin_sum;
    logic             coin_fits;
    logic [WIDTH-1:0] vend_rem;

    coin_value_lut #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W),
        .COIN0 (COIN0),
        .COIN1 (COIN1),
        .COIN2 (COIN2),
        .COIN3 (COIN3)
    ) u_lut (
        .sel   (COIN_SEL),
        .value (coin_val)
    );

    // One spare bit so an overflowing sum is caught rather than wrapped.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_fits = (coin_val != '0) && (coin_sum <= (WIDTH+1)'(MAX_CREDIT));
    assign vend_rem  = credit_q - PRICE;

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        change_valid_d = change_valid_q;
        coin_ack_d     = 1'b0;
        coin_rej_d     = 1'b0;
        vend_ok_d      = 1'b0;
        vend_deny_d    = 1'b0;

        if (state_q == ST_REFUND) begin
            coin_rej_d  = COIN_VALID;
            vend_deny_d = VEND_REQ;
            if (CHANGE_ACK) begin
                change_valid_d = 1'b0;
                change_d       = '0;
                state_d        = ST_IDLE;
            end
        end else if (CANCEL && state_q == ST_HOLD) begin
            coin_rej_d     = COIN_VALID;
            change_d       = credit_q;
            change_valid_d = 1'b1;
            credit_d       = '0;
            state_d        = ST_REFUND;
        end else if (VEND_REQ) begin
            // A coin arriving with a cancel or vend is always bounced.
            coin_rej_d = COIN_VALID;
            if (credit_q >= PRICE) begin
                vend_ok_d = 1'b1;
                credit_d  = '0;
                if (vend_rem != '0) begin
                    change_d       = vend_rem;
                    change_valid_d = 1'b1;
                    state_d        = ST_REFUND;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                vend_deny_d = 1'b1;
            end
        end else if (COIN_VALID) begin
            if (CANCEL || !coin_fits) begin
                coin_rej_d = 1'b1;
            end else begin
                coin_ack_d = 1'b1;
                credit_d   = coin_sum[WIDTH-1:0];
                state_d    = ST_HOLD;
            end
        end

        busy_d = (state_d == ST_REFUND);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            coin_ack_q     <= 1'b0;
            coin_rej_q     <= 1'b0;
            vend_ok_q      <= 1'b0;
            vend_deny_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            coin_ack_q     <= coin_ack_d;
            coin_rej_q     <= coin_rej_d;
            vend_ok_q      <= vend_ok_d;
            vend_deny_q    <= vend_deny_d;
            busy_q         <= busy_d;
        end
    end

    assign COIN_ACK     = coin_ack_q;
    assign COIN_REJ     = coin_rej_q;
    assign VEND_OK      = vend_ok_q;
    assign VEND_DENY    = vend_deny_q;
    assign CHANGE_VALID = change_valid_q;
    assign CHANGE       = change_q;
    assign CREDIT       = credit_q;
    assign BUSY         = busy_q;

endmodule
